apb2axi_txn_mgr: RTL

- Consumer side of the APB2AXI request directory. Pops PENDING entries (in tag order) and issues each as a single AXI read-address (AR) or write-address (AW) beat.
- Tracks outstanding tags until the response path reports completion.
- Enforces a global outstanding-credit limit and prevents a tag from being reissued while it is still in flight.
- Sits between the directory and the AXI master address channels, in the single APB clock domain.

---
 rtl/apb2axi_txn_mgr_if.sv | 45 ++++
 rtl/apb2axi_txn_mgr.sv | 89 ++++++++
 2 files changed

// File: rtl/apb2axi_txn_mgr_if.sv
// apb2axi_txn_mgr_if: shared types plus the AXI AR/AW address-channel bundle.
// Ports (modport master = address issuer, slave = AXI fabric):
//   ar_valid/ar_ready, ar_id, ar_addr, ar_len, ar_size, ar_burst
//   aw_valid/aw_ready, aw_id, aw_addr, aw_len, aw_size, aw_burst
package apb2axi_txn_mgr_pkg;
    localparam int TAG_NUM    = 8;
    localparam int TAG_W      = $clog2(TAG_NUM);
    localparam int AXI_ADDR_W = 32;
    typedef struct packed {
        logic [AXI_ADDR_W-1:0] addr;
        logic [7:0]            len;
        logic [2:0]            size;
        logic [1:0]            burst;
        logic                  is_write;
        logic [TAG_W-1:0]      tag;
    } directory_entry_t;
endpackage

interface apb2axi_txn_mgr_if #(
    parameter int ID_W   = apb2axi_txn_mgr_pkg::TAG_W,
    parameter int ADDR_W = apb2axi_txn_mgr_pkg::AXI_ADDR_W
);
    logic              ar_valid, ar_ready;
    logic [ID_W-1:0]   ar_id;
    logic [ADDR_W-1:0] ar_addr;
    logic [7:0]        ar_len;
    logic [2:0]        ar_size;
    logic [1:0]        ar_burst;
    logic              aw_valid, aw_ready;
    logic [ID_W-1:0]   aw_id;
    logic [ADDR_W-1:0] aw_addr;
    logic [7:0]        aw_len;
    logic [2:0]        aw_size;
    logic [1:0]        aw_burst;
    modport master (
        output ar_valid, ar_id, ar_addr, ar_len, ar_size, ar_burst,
        output aw_valid, aw_id, aw_addr, aw_len, aw_size, aw_burst,
        input  ar_ready, aw_ready
    );
    modport slave (
        input  ar_valid, ar_id, ar_addr, ar_len, ar_size, ar_burst,
        input  aw_valid, aw_id, aw_addr, aw_len, aw_size, aw_burst,
        output ar_ready, aw_ready
    );
endinterface

// File: rtl/apb2axi_txn_mgr.sv
// apb2axi_txn_mgr: pops PENDING directory entries and issues each as one AXI AR/AW beat,
// tracking in-flight tags and a global outstanding-credit limit.
// Ports:
//   pclk, presetn                          clock, async active-low reset
//   pending_valid/entry/tag, pending_pop   directory side
//   axi (master)                           AR/AW address channels
//   issue_tag, issue_valid                 strobe on each completed address handshake
//   cmpl_valid, cmpl_tag                   completion from the response path
//   outst_cnt, busy_vec, idle, err_cmpl    status
module apb2axi_txn_mgr
    import apb2axi_txn_mgr_pkg::*;
#(
    parameter int TAG_NUM_P   = TAG_NUM,
    parameter int TAG_W_P     = TAG_W,
    parameter int MAX_OUTST_P = TAG_NUM,
    localparam int CW         = $clog2(MAX_OUTST_P + 1)
) (
    input  logic                 pclk,
    input  logic                 presetn,
    input  logic                 pending_valid,
    input  directory_entry_t     pending_entry,
    input  logic [TAG_W_P-1:0]   pending_tag,
    output logic                 pending_pop,
    apb2axi_txn_mgr_if.master    axi,
    output logic [TAG_W_P-1:0]   issue_tag,
    output logic                 issue_valid,
    input  logic                 cmpl_valid,
    input  logic [TAG_W_P-1:0]   cmpl_tag,
    output logic [CW-1:0]        outst_cnt,
    output logic [TAG_NUM_P-1:0] busy_vec,
    output logic                 idle,
    output logic                 err_cmpl
);
    typedef enum logic [1:0] {S_IDLE, S_AR, S_AW} state_t;
    state_t               state;
    logic [TAG_W_P-1:0]   id_q;
    logic [AXI_ADDR_W-1:0] addr_q;
    logic [7:0]           len_q;
    logic [2:0]           size_q;
    logic [1:0]           burst_q;
    logic                 cmpl_ok;
    logic                 unused_entry_tag;
    assign unused_entry_tag = ^pending_entry.tag;
    // Pop and credit decisions look only at registered state, so cmpl_valid never reaches pending_pop.
    assign pending_pop = state == S_IDLE && pending_valid && outst_cnt < CW'(MAX_OUTST_P) && !busy_vec[pending_tag];
    assign cmpl_ok     = cmpl_valid && busy_vec[cmpl_tag];
    assign issue_valid = (state == S_AR && axi.ar_ready) || (state == S_AW && axi.aw_ready);
    assign issue_tag   = id_q;
    assign idle        = state == S_IDLE && outst_cnt == '0;
    assign axi.ar_valid = state == S_AR;
    assign axi.aw_valid = state == S_AW;
    assign axi.ar_id    = id_q;
    assign axi.aw_id    = id_q;
    assign axi.ar_addr  = addr_q;
    assign axi.aw_addr  = addr_q;
    assign axi.ar_len   = len_q;
    assign axi.aw_len   = len_q;
    assign axi.ar_size  = size_q;
    assign axi.aw_size  = size_q;
    assign axi.ar_burst = burst_q;
    assign axi.aw_burst = burst_q;
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state     <= S_IDLE;
            id_q      <= '0;
            addr_q    <= '0;
            len_q     <= '0;
            size_q    <= '0;
            burst_q   <= '0;
            outst_cnt <= '0;
            busy_vec  <= '0;
            err_cmpl  <= 1'b0;
        end else begin
            state <= state == S_IDLE ? (pending_pop ? (pending_entry.is_write ? S_AW : S_AR) : S_IDLE)
                                     : (issue_valid ? S_IDLE : state);
            if (pending_pop) begin
                id_q    <= pending_tag;
                addr_q  <= pending_entry.addr;
                len_q   <= pending_entry.len;
                size_q  <= pending_entry.size;
                burst_q <= pending_entry.burst;
            end
            // Credit is reserved at pop; a pop and a legal completion in one cycle cancel out.
            outst_cnt <= outst_cnt + CW'(pending_pop) - CW'(cmpl_ok);
            busy_vec  <= (busy_vec | (TAG_NUM_P'(pending_pop) << pending_tag)) & ~(TAG_NUM_P'(cmpl_ok) << cmpl_tag);
            err_cmpl  <= err_cmpl | (cmpl_valid && !busy_vec[cmpl_tag]);
        end
    end
endmodule
